// File: rtl/puf_response_collector.sv
// PUF response collector: sweeps the external 16:1 response mux select,
// waits for the mux output to settle at each select, majority-votes several
// samples per bit and presents the assembled 16-bit word with valid/ready.
module puf_response_collector #(
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned SAMPLES_PER_BIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mux_out,
  output logic [3:0]  sel,
  output logic        busy,
  output logic        resp_valid,
  output logic [15:0] resp,
  input  logic        resp_ready
);

  localparam int unsigned OnesW = $clog2(SAMPLES_PER_BIT + 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e             state_q;
  logic [7:0]         settle_cnt_q;
  logic [3:0]         sample_cnt_q;
  logic [OnesW-1:0]   ones_q;
  logic [15:0]        shadow_q;

  logic [OnesW-1:0]   ones_next;
  logic               bit_vote;
  logic               last_settle;
  logic               last_sample;

  // Vote includes the sample taken on the current edge.
  always_comb begin
    ones_next   = ones_q + OnesW'(mux_out);
    bit_vote    = (ones_next > OnesW'(SAMPLES_PER_BIT / 2));
    last_settle = (settle_cnt_q == 8'(SETTLE_CYCLES - 1));
    last_sample = (sample_cnt_q == 4'(SAMPLES_PER_BIT - 1));
  end

  // Sweep sequencer with registered outputs; resp only updates on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      settle_cnt_q <= '0;
      sample_cnt_q <= '0;
      ones_q       <= '0;
      shadow_q     <= '0;
      sel          <= '0;
      busy         <= 1'b0;
      resp_valid   <= 1'b0;
      resp         <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q      <= StSettle;
            sel          <= '0;
            busy         <= 1'b1;
            settle_cnt_q <= '0;
            ones_q       <= '0;
          end
        end
        StSettle: begin
          if (last_settle) begin
            state_q      <= StSample;
            sample_cnt_q <= '0;
          end else begin
            settle_cnt_q <= settle_cnt_q + 8'd1;
          end
        end
        StSample: begin
          if (last_sample) begin
            shadow_q[sel] <= bit_vote;
            ones_q        <= '0;
            if (sel != 4'd15) begin
              sel          <= sel + 4'd1;
              settle_cnt_q <= '0;
              state_q      <= StSettle;
            end else begin
              resp       <= {bit_vote, shadow_q[14:0]};
              resp_valid <= 1'b1;
              busy       <= 1'b0;
              sel        <= '0;
              state_q    <= StDone;
            end
          end else begin
            ones_q       <= ones_next;
            sample_cnt_q <= sample_cnt_q + 4'd1;
          end
        end
        StDone: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
